sprite_line_engine: RTL

- Parametrised successor to the per-sprite foreground matcher array. Holds the sprite attribute table in CPU-visible registers.
- During each line's blanking, an evaluation scan selects at most SLOTS visible sprites for the next line into a double-buffered slot list.
- During active pixels, it outputs tile number and in-tile offsets for the highest-priority hit, feeding the tile fetch stage of the GPU pipeline.

---
 rtl/sprite_line_engine_if.sv | 10 +
 rtl/sprite_line_engine.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_engine_if.sv
// CPU-side address/control bundle for the sprite line engine; the data bus
// itself stays a plain inout on the engine so tristate resolution is simple.
interface sprite_line_engine_if;
    logic [29:0] data_address;
    logic        data_cs;
    logic        data_rw;

    modport master (output data_address, output data_cs, output data_rw);
    modport slave  (input  data_address, input  data_cs, input  data_rw);
endinterface

// File: rtl/sprite_line_engine.sv
// Sprite attribute table, per-line evaluation scan into double-buffered slots,
// and per-pixel resolve. Optional flip support is enabled by SPRITE_FLIP_EN.
module sprite_line_engine #(
    parameter int          SPRITES   = 64,
    parameter int          SLOTS     = 8,
    parameter int          SPRITE_W  = 16,
    parameter int          SPRITE_H  = 16,
    parameter logic [31:0] BASE_ADDR = 32'h70100000
) (
    input  logic                 gpu_clk,
    input  logic                 reset,
    sprite_line_engine_if.slave  bus,
    inout  wire  [31:0]          data_bus,
    input  logic                 line_start,
    input  logic [15:0]          next_line,
    input  logic [15:0]          pixel,
    output logic [15:0]          tile_number,
    output logic [7:0]           offset_x,
    output logic [7:0]           offset_y,
    output logic                 scan_busy
);
    localparam int IDXW = (SPRITES > 1) ? $clog2(SPRITES) : 1;
    localparam int CW   = $clog2(SLOTS + 1);
    localparam int SW   = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [29:0]     LP_BASE   = BASE_ADDR[31:2];
    localparam logic [29:0]     LP_STATUS = 30'(2 * SPRITES);
    localparam logic [15:0]     LP_W      = 16'(SPRITE_W);
    localparam logic [15:0]     LP_H      = 16'(SPRITE_H);
    localparam logic [IDXW-1:0] LP_LAST   = IDXW'(SPRITES - 1);
    localparam logic [CW-1:0]   LP_SLOTS  = CW'(SLOTS);

    typedef enum logic {IDLE, SCAN} scanState_t;
    scanState_t r_state, w_nextState;

    logic [15:0] r_attrX     [SPRITES];
    logic [15:0] r_attrY     [SPRITES];
    logic [15:0] r_attrTile  [SPRITES];
    logic [15:0] r_attrFlags [SPRITES];

    logic [15:0] r_slotX    [2][SLOTS];
    logic [15:0] r_slotTile [2][SLOTS];
    logic [7:0]  r_slotRow  [2][SLOTS];
`ifdef SPRITE_FLIP_EN
    logic        r_slotHflip [2][SLOTS];
`endif
    logic [CW-1:0]   r_count [2];
    logic            r_scanBank;
    logic            r_overflow;
    logic [7:0]      r_lastCount;
    logic [IDXW-1:0] r_idx;
    logic [15:0]     r_scanLine;

    logic [29:0]     w_off;
    logic            w_inRange, w_isStatus, w_rdEn, w_wrEn, w_statusRead;
    logic [IDXW-1:0] w_entry;
    logic [31:0]     w_rdata;

    assign w_off        = bus.data_address - LP_BASE;
    assign w_inRange    = (bus.data_address >= LP_BASE) && (w_off <= LP_STATUS);
    assign w_isStatus   = w_inRange && (w_off == LP_STATUS);
    assign w_entry      = w_off[IDXW:1];
    assign w_rdEn       = bus.data_cs && bus.data_rw && w_inRange;
    assign w_wrEn       = bus.data_cs && !bus.data_rw && w_inRange && !w_isStatus;
    assign w_statusRead = bus.data_cs && bus.data_rw && w_isStatus;

    always_comb begin
        w_rdata = '0;
        if (w_isStatus)
            w_rdata = {r_overflow, 23'b0, r_lastCount};
        else if (w_off[0])
            w_rdata = {r_attrFlags[w_entry], r_attrTile[w_entry]};
        else
            w_rdata = {r_attrY[w_entry], r_attrX[w_entry]};
    end

    assign data_bus = w_rdEn ? w_rdata : 'z;

    // Scan evaluates the entry at r_idx using the attribute values held this cycle.
    logic [15:0]   w_dy;
    logic          w_hit, w_slotFree, w_store;
    logic [7:0]    w_row;
    logic [CW-1:0] w_finalCount;
    logic [SW-1:0] w_slotIdx;

    assign w_dy       = r_scanLine - r_attrY[r_idx];
    assign w_hit      = (r_state == SCAN) && (r_attrTile[r_idx] != 16'hFFFF) && (w_dy < LP_H);
    assign w_slotFree = r_count[r_scanBank] < LP_SLOTS;
    assign w_store    = w_hit && w_slotFree && !line_start;
    assign w_slotIdx  = r_count[r_scanBank][SW-1:0];
    assign w_finalCount = r_count[r_scanBank] + CW'(w_store);
`ifdef SPRITE_FLIP_EN
    assign w_row = r_attrFlags[r_idx][1] ? (8'(SPRITE_H - 1) - w_dy[7:0]) : w_dy[7:0];
`else
    assign w_row = w_dy[7:0];
`endif

    always_ff @(posedge gpu_clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        scan_busy   = 1'b0;
        case (r_state)
            IDLE: if (line_start) w_nextState = SCAN;
            SCAN: begin
                scan_busy = 1'b1;
                if (!line_start && r_idx == LP_LAST) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge gpu_clk) begin
        if (reset) begin
            for (int i = 0; i < SPRITES; i++) begin
                r_attrX[i]     <= '0;
                r_attrY[i]     <= '0;
                r_attrTile[i]  <= 16'hFFFF;
                r_attrFlags[i] <= '0;
            end
            r_count[0]  <= '0;
            r_count[1]  <= '0;
            r_scanBank  <= 1'b0;
            r_overflow  <= 1'b0;
            r_lastCount <= '0;
            r_idx       <= '0;
            r_scanLine  <= '0;
        end else begin
            if (w_wrEn) begin
                if (w_off[0]) {r_attrFlags[w_entry], r_attrTile[w_entry]} <= data_bus;
                else          {r_attrY[w_entry], r_attrX[w_entry]}        <= data_bus;
            end
            if (w_statusRead) r_overflow <= 1'b0;
            // A new line always swaps banks, even mid-scan, so the partial list is shown.
            if (line_start) begin
                r_scanBank           <= ~r_scanBank;
                r_count[~r_scanBank] <= '0;
                r_scanLine           <= next_line;
                r_idx                <= '0;
            end else if (r_state == SCAN) begin
                r_idx <= r_idx + 1'b1;
                if (w_store)               r_count[r_scanBank] <= w_finalCount;
                if (w_hit && !w_slotFree)  r_overflow <= 1'b1;
                if (r_idx == LP_LAST)      r_lastCount <= 8'(w_finalCount);
            end
        end
    end

    always_ff @(posedge gpu_clk) begin
        if (!reset && r_state == SCAN && w_store) begin
            r_slotX[r_scanBank][w_slotIdx]    <= r_attrX[r_idx];
            r_slotTile[r_scanBank][w_slotIdx] <= r_attrTile[r_idx];
            r_slotRow[r_scanBank][w_slotIdx]  <= w_row;
`ifdef SPRITE_FLIP_EN
            r_slotHflip[r_scanBank][w_slotIdx] <= r_attrFlags[r_idx][0];
`endif
        end
    end

    // Scan from slot 0 upward and keep the first match, which is the lowest sprite index.
    logic        w_dispBank, w_found;
    logic [15:0] w_dx, w_resTile;
    logic [7:0]  w_resOx, w_resOy;

    assign w_dispBank = ~r_scanBank;

    always_comb begin
        w_found   = 1'b0;
        w_dx      = '0;
        w_resTile = 16'hFFFF;
        w_resOx   = '0;
        w_resOy   = '0;
        for (int s = 0; s < SLOTS; s++) begin
            w_dx = pixel - r_slotX[w_dispBank][s];
            if (!w_found && (CW'(s) < r_count[w_dispBank]) && (w_dx < LP_W)) begin
                w_found   = 1'b1;
                w_resTile = r_slotTile[w_dispBank][s];
                w_resOy   = r_slotRow[w_dispBank][s];
`ifdef SPRITE_FLIP_EN
                w_resOx   = r_slotHflip[w_dispBank][s] ? (8'(SPRITE_W - 1) - w_dx[7:0]) : w_dx[7:0];
`else
                w_resOx   = w_dx[7:0];
`endif
            end
        end
    end

    always_ff @(posedge gpu_clk) begin
        if (reset) begin
            tile_number <= 16'hFFFF;
            offset_x    <= '0;
            offset_y    <= '0;
        end else begin
            tile_number <= w_resTile;
            offset_x    <= w_resOx;
            offset_y    <= w_resOy;
        end
    end
endmodule
